// File: rtl/pcm_fetch_pkg.sv
// Shared definitions for the PCM prefetch path: bus FSM states and address defaults.
package pcm_fetch_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam logic [ADDR_W-1:0] START_DEFAULT = 25'h2C;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_RELEASE,
    F_DONE
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO of 16-bit words; head word is visible combinationally.
module sync_fifo_sa #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [15:0]              wdata_i,
  output logic [15:0]              rdata_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/pcm_prefetch_fifo.sv
// Sequential PCM word fetcher: Avalon read FSM feeding a show-ahead sample FIFO.
module pcm_prefetch_fifo
  import pcm_fetch_pkg::*;
#(
  parameter int unsigned        DEPTH         = 16,
  parameter int unsigned        ADDR_W        = pcm_fetch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]  START_DEFAULT = ADDR_W'(pcm_fetch_pkg::START_DEFAULT)
) (
  input  logic                    clk50,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    addr_load,
  input  logic [ADDR_W-1:0]       addr_start,
  input  logic [ADDR_W-1:0]       addr_end,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rden,
  input  logic [15:0]             mem_rddata,
  input  logic                    mem_ack,
  output logic [15:0]             smp_data,
  output logic                    smp_valid,
  input  logic                    smp_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underrun,
  output logic                    done
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
  logic              discard_q, discard_d;
  logic              underrun_q, underrun_d;
  logic              push;
  logic [LW-1:0]     fifo_level;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    end_d     = end_q;
    discard_d = discard_q;
    push      = 1'b0;
    if (addr_load) begin
      addr_d = addr_start;
      end_d  = addr_end;
    end
    unique case (state_q)
      F_IDLE: begin
        discard_d = 1'b0;
        if (!addr_load && enable && (fifo_level < LW'(DEPTH))) state_d = F_REQ;
      end
      F_REQ: begin
        if (addr_load) discard_d = 1'b1;
        if (mem_ack) begin
          push    = !discard_q && !addr_load;
          state_d = F_RELEASE;
        end
      end
      F_RELEASE: begin
        if (mem_ack) begin
          if (addr_load) discard_d = 1'b1;
        end else begin
          // A load or pending discard ends the transaction without touching the loaded address.
          state_d = F_IDLE;
          if (addr_load || discard_q) discard_d = 1'b0;
          else if (addr_q >= end_q)   state_d   = F_DONE;
          else                        addr_d    = addr_q + 1'b1;
        end
      end
      F_DONE: begin
        if (addr_load) state_d = F_IDLE;
      end
    endcase
  end

  assign underrun_d = smp_ready && !smp_valid && enable && (state_q != F_DONE);

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q    <= F_IDLE;
      addr_q     <= START_DEFAULT;
      end_q      <= '1;
      discard_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
      discard_q  <= discard_d;
      underrun_q <= underrun_d;
    end
  end

  sync_fifo_sa #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk50),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (smp_ready),
    .flush_i (addr_load),
    .wdata_i (mem_rddata),
    .rdata_o (smp_data),
    .level_o (fifo_level)
  );

  assign mem_rden  = (state_q == F_REQ);
  assign mem_addr  = addr_q;
  assign done      = (state_q == F_DONE);
  assign underrun  = underrun_q;
  assign level     = fifo_level;
  assign smp_valid = (fifo_level != '0);

endmodule

// File: tb/tb_pcm_prefetch_fifo.sv
// Directed bench for pcm_prefetch_fifo with a latency-configurable memory responder.
module tb_pcm_prefetch_fifo;

  logic        clk50 = 1'b0;
  logic        reset, enable, addr_load;
  logic [24:0] addr_start, addr_end, mem_addr;
  logic        mem_rden, mem_ack;
  logic [15:0] mem_rddata, smp_data;
  logic        smp_valid, smp_ready, underrun, done;
  logic [4:0]  level;

  always #5 clk50 = ~clk50;

  pcm_prefetch_fifo #(.DEPTH(16), .ADDR_W(25), .START_DEFAULT(25'h2C)) dut (
    .clk50      (clk50),
    .reset      (reset),
    .enable     (enable),
    .addr_load  (addr_load),
    .addr_start (addr_start),
    .addr_end   (addr_end),
    .mem_addr   (mem_addr),
    .mem_rden   (mem_rden),
    .mem_rddata (mem_rddata),
    .mem_ack    (mem_ack),
    .smp_data   (smp_data),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .level      (level),
    .underrun   (underrun),
    .done       (done)
  );

  // Memory responder: word at address A holds A[15:0]; address latched when the request appears.
  int          lat, hold, cnt;
  logic        stall, busy;
  logic [15:0] req_addr;

  always @(posedge clk50) begin
    if (reset) begin
      busy <= 1'b0; cnt <= 0; mem_ack <= 1'b0; mem_rddata <= '0; req_addr <= '0;
    end else if (!busy) begin
      if (mem_rden) begin
        busy <= 1'b1; cnt <= 0; req_addr <= mem_addr[15:0];
      end
    end else if (!stall) begin
      cnt <= cnt + 1;
      if (cnt + 1 == lat) begin mem_ack <= 1'b1; mem_rddata <= req_addr; end
      if (cnt + 1 == lat + hold) begin mem_ack <= 1'b0; busy <= 1'b0; end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic go_idle();
    enable = 1'b0; smp_ready = 1'b0;
    repeat (25) @(negedge clk50);
  endtask

  task automatic load(input logic [24:0] s, input logic [24:0] e);
    addr_start = s; addr_end = e; addr_load = 1'b1;
    @(negedge clk50);
    addr_load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          n, got;
    logic [31:0] exp;
    logic        seen, und;

    reset = 1'b1; enable = 1'b0; addr_load = 1'b0; addr_start = '0; addr_end = '0;
    smp_ready = 1'b0; stall = 1'b0; lat = 2; hold = 1;
    repeat (3) @(negedge clk50);
    check("rst_rden",     mem_rden,  0);
    check("rst_addr",     mem_addr,  32'h2C);
    check("rst_valid",    smp_valid, 0);
    check("rst_data",     smp_data,  0);
    check("rst_level",    level,     0);
    check("rst_underrun", underrun,  0);
    check("rst_done",     done,      0);
    reset = 1'b0;

    // Fill from the reset start address until the FIFO is full.
    enable = 1'b1;
    for (n = 0; n < 50 && !mem_rden; n++) @(negedge clk50);
    check("first_req_to", n < 50, 1);
    check("first_addr", mem_addr, 32'h2C);
    for (n = 0; n < 100 && !smp_valid; n++) @(negedge clk50);
    check("first_valid_to", n < 100, 1);
    check("first_data", smp_data, 32'h2C);
    check("first_level", level, 1);
    for (n = 0; n < 1000 && level != 5'd16; n++) @(negedge clk50);
    check("fill_to", n < 1000, 1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk50); seen |= mem_rden; end
    check("full_no_req", seen, 0);
    check("full_head", smp_data, 32'h2C);

    // One pop, then pop on the refill capture edge.
    smp_ready = 1'b1; @(negedge clk50); smp_ready = 1'b0;
    check("pop_level", level, 15);
    check("pop_head", smp_data, 32'h2D);
    for (n = 0; n < 100 && !mem_ack; n++) @(negedge clk50);
    check("refill_ack_to", n < 100, 1);
    check("refill_addr", mem_addr, 32'h3C);
    smp_ready = 1'b1; @(negedge clk50); smp_ready = 1'b0;
    check("pushpop_level", level, 15);
    check("pushpop_head", smp_data, 32'h2E);

    // Drain continuously across pointer wrap; words must stay consecutive.
    smp_ready = 1'b1; exp = 32'h2E; got = 0;
    for (n = 0; n < 2000 && got < 30; n++) begin
      if (smp_valid) begin check("stream", smp_data, exp); exp++; got++; end
      @(negedge clk50);
    end
    smp_ready = 1'b0;
    check("stream_cnt", got, 30);

    // Long ack: one push per transaction, address steps only after ack falls.
    go_idle();
    load(25'h300, 25'h3FF);
    check("ld_level", level, 0);
    check("ld_addr", mem_addr, 32'h300);
    check("ld_done", done, 0);
    hold = 5; enable = 1'b1;
    for (n = 0; n < 100 && !mem_ack; n++) @(negedge clk50);
    check("h5_ack_to", n < 100, 1);
    seen = 1'b0;
    for (n = 0; n < 20 && mem_ack; n++) begin seen |= (mem_addr != 25'h300); @(negedge clk50); end
    check("h5_addr_stable", seen, 0);
    check("h5_level", level, 1);
    check("h5_addr_hold", mem_addr, 32'h300);
    @(negedge clk50);
    check("h5_addr_step", mem_addr, 32'h301);
    check("h5_level2", level, 1);
    check("h5_head", smp_data, 32'h300);

    // Bounded range with an always-ready consumer.
    go_idle();
    hold = 1;
    load(25'h100, 25'h103);
    smp_ready = 1'b1; enable = 1'b1; exp = 32'h100; got = 0;
    for (n = 0; n < 500 && got < 4; n++) begin
      if (smp_valid) begin check("seq", smp_data, exp); exp++; got++; end
      @(negedge clk50);
    end
    check("seq_cnt", got, 4);
    for (n = 0; n < 100 && !done; n++) @(negedge clk50);
    check("done_to", n < 100, 1);
    @(negedge clk50);
    seen = 1'b0; und = 1'b0;
    repeat (30) begin @(negedge clk50); seen |= mem_rden; und |= underrun; end
    check("done_no_req", seen, 0);
    check("done_no_underrun", und, 0);
    check("done_empty", smp_valid, 0);
    check("done_data0", smp_data, 0);

    // Start beyond end: exactly one word, then done.
    smp_ready = 1'b0;
    load(25'h500, 25'h4FF);
    check("rev_done_clr", done, 0);
    for (n = 0; n < 100 && !smp_valid; n++) @(negedge clk50);
    check("rev_valid_to", n < 100, 1);
    check("rev_data", smp_data, 32'h500);
    for (n = 0; n < 100 && !done; n++) @(negedge clk50);
    check("rev_done_to", n < 100, 1);
    seen = 1'b0;
    repeat (20) begin @(negedge clk50); seen |= mem_rden; end
    check("rev_no_req", seen, 0);
    check("rev_level", level, 1);

    // Stalled bus: underrun pulses; reload mid-request discards the in-flight word.
    go_idle();
    load(25'h40, 25'hFF);
    stall = 1'b1; enable = 1'b1;
    for (n = 0; n < 50 && !mem_rden; n++) @(negedge clk50);
    check("stall_req_to", n < 50, 1);
    check("stall_req_addr", mem_addr, 32'h40);
    smp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk50);
      check("underrun", underrun, 1);
      check("underrun_data", smp_data, 0);
    end
    smp_ready = 1'b0;
    @(negedge clk50);
    check("underrun_off", underrun, 0);
    load(25'h200, 25'h2FF);
    check("dis_level", level, 0);
    check("dis_addr", mem_addr, 32'h200);
    stall = 1'b0;
    for (n = 0; n < 100 && !smp_valid; n++) @(negedge clk50);
    check("dis_valid_to", n < 100, 1);
    check("dis_first", smp_data, 32'h200);
    check("dis_level1", level, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
